// File: rtl/ddr3_local_burst_master.sv
// rtl/ddr3_local_burst_master.sv - client command to DDR3 local-interface burst master
module ddr3_local_burst_master #(
  parameter int ADDR_W       = 25,
  parameter int SIZE_W       = 7,
  parameter int DATA_W       = 128,
  parameter int BE_W         = 16,
  parameter int MAX_RD_BEATS = 64
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [SIZE_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              idle,
  output logic              rd_overflow,
  input  logic              local_init_done,
  input  logic              local_ready,
  output logic [ADDR_W-1:0] local_address,
  output logic [SIZE_W-1:0] local_size,
  output logic              local_burstbegin,
  output logic              local_read_req,
  output logic              local_write_req,
  output logic [DATA_W-1:0] local_wdata,
  output logic [BE_W-1:0]   local_be,
  input  logic              local_rdata_valid,
  input  logic [DATA_W-1:0] local_rdata
);

  localparam int CNT_W = $clog2(MAX_RD_BEATS) + 1;
  // Wide enough that rd_out + len never wraps before the limit compare.
  localparam int SUM_W = ((CNT_W > SIZE_W) ? CNT_W : SIZE_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_REQ   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SIZE_W-1:0]   beat_q, beat_d;
  logic                first_q, first_d;
  logic [CNT_W-1:0]    rd_out_q, rd_out_d;
  logic                overflow_q, overflow_d;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic [SIZE_W-1:0]   len_eff;
  logic [SUM_W-1:0]    rd_sum;
  logic                rd_fits;
  logic                rd_issue;
  logic                rd_dec;

  // A zero-length command is a single beat.
  assign len_eff = (cmd_len == '0) ? SIZE_W'(1) : cmd_len;
  assign rd_sum  = SUM_W'(rd_out_q) + SUM_W'(len_eff);
  assign rd_fits = (rd_sum <= SUM_W'(MAX_RD_BEATS));

  assign local_wdata   = wr_data;
  assign local_be      = wr_be;
  assign local_address = addr_q;
  assign local_size    = size_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_overflow   = overflow_q;
  assign idle          = (state_q == S_IDLE) && (rd_out_q == '0);

  // Next-state and local-interface request decode.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    size_d           = size_q;
    beat_d           = beat_q;
    first_d          = first_q;
    cmd_ready        = 1'b0;
    wr_ready         = 1'b0;
    local_write_req  = 1'b0;
    local_read_req   = 1'b0;
    local_burstbegin = 1'b0;
    rd_issue         = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = local_init_done && (cmd_write || rd_fits);
        if (cmd_valid && local_init_done && (cmd_write || rd_fits)) begin
          addr_d  = cmd_addr;
          size_d  = len_eff;
          beat_d  = len_eff;
          first_d = 1'b1;
          state_d = cmd_write ? S_WR_BURST : S_RD_REQ;
        end
      end
      S_WR_BURST: begin
        local_write_req  = wr_valid;
        wr_ready         = local_ready;
        local_burstbegin = wr_valid && first_q;
        if (wr_valid && local_ready) begin
          beat_d  = beat_q - SIZE_W'(1);
          first_d = 1'b0;
          if (beat_q == SIZE_W'(1)) state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        if (local_ready) begin
          rd_issue = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outstanding read beats; a return with nothing outstanding is flagged, not counted.
  always_comb begin
    rd_dec     = local_rdata_valid && (rd_out_q != '0);
    overflow_d = overflow_q || (local_rdata_valid && (rd_out_q == '0));
    rd_out_d   = rd_out_q + (rd_issue ? CNT_W'(size_q) : '0) - (rd_dec ? CNT_W'(1) : '0);
  end

  // Control state registers.
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      beat_q     <= '0;
      first_q    <= 1'b0;
      rd_out_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      beat_q     <= beat_d;
      first_q    <= first_d;
      rd_out_q   <= rd_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Read return path: one-cycle registered copy of the controller's read data.
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= local_rdata_valid;
      rd_data_q  <= local_rdata;
    end
  end

endmodule

// File: tb/tb_ddr3_local_burst_master.sv
// tb/tb_ddr3_local_burst_master.sv - directed self-checking bench for ddr3_local_burst_master
module tb_ddr3_local_burst_master;

  logic          phy_clk = 1'b0;
  logic          reset_phy_clk_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [24:0]   cmd_addr;
  logic [6:0]    cmd_len;
  logic          wr_valid, wr_ready;
  logic [127:0]  wr_data;
  logic [15:0]   wr_be;
  logic          rd_valid;
  logic [127:0]  rd_data;
  logic          idle, rd_overflow;
  logic          local_init_done, local_ready;
  logic [24:0]   local_address;
  logic [6:0]    local_size;
  logic          local_burstbegin, local_read_req, local_write_req;
  logic [127:0]  local_wdata;
  logic [15:0]   local_be;
  logic          local_rdata_valid;
  logic [127:0]  local_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 phy_clk = ~phy_clk;

  ddr3_local_burst_master dut (
    .phy_clk(phy_clk), .reset_phy_clk_n(reset_phy_clk_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_data(rd_data), .idle(idle), .rd_overflow(rd_overflow),
    .local_init_done(local_init_done), .local_ready(local_ready),
    .local_address(local_address), .local_size(local_size),
    .local_burstbegin(local_burstbegin), .local_read_req(local_read_req),
    .local_write_req(local_write_req), .local_wdata(local_wdata), .local_be(local_be),
    .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata)
  );

  task automatic test_reset();
    #1;
    total_cnt++; if (idle !== 1'b1) $display("FAIL rst_idle got=%b exp=1", idle); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    total_cnt++; if (local_write_req !== 1'b0 || local_read_req !== 1'b0 || local_burstbegin !== 1'b0)
      $display("FAIL rst_reqs got=%b%b%b exp=000", local_write_req, local_read_req, local_burstbegin); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0 || rd_overflow !== 1'b0 || wr_ready !== 1'b0)
      $display("FAIL rst_flags got=%b%b%b exp=000", rd_valid, rd_overflow, wr_ready); else pass_cnt++;
    total_cnt++; if (local_address !== 25'h0 || local_size !== 7'h0)
      $display("FAIL rst_addr_size got=%h/%h exp=0/0", local_address, local_size); else pass_cnt++;
  endtask

  task automatic test_write4();
    logic [127:0] d;
    @(negedge phy_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 25'h100; cmd_len = 7'd4;
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL wr4_cmd_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge phy_clk);
      cmd_valid = 1'b0; wr_valid = 1'b1;
      d = 128'hBEEF_0000 + 128'(i);
      wr_data = d; wr_be = 16'hF0F0;
      #1;
      total_cnt++; if (local_write_req !== 1'b1) $display("FAIL wr4_req beat%0d got=%b exp=1", i, local_write_req); else pass_cnt++;
      total_cnt++; if (local_burstbegin !== (i == 0)) $display("FAIL wr4_bb beat%0d got=%b exp=%b", i, local_burstbegin, (i == 0)); else pass_cnt++;
      total_cnt++; if (local_wdata !== d || local_be !== 16'hF0F0) $display("FAIL wr4_data beat%0d got=%h exp=%h", i, local_wdata, d); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (local_size !== 7'd4 || local_address !== 25'h100)
          $display("FAIL wr4_size_addr got=%h/%h exp=4/100", local_size, local_address); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL wr4_cmd_ready_busy got=%b exp=0", cmd_ready); else pass_cnt++;
      end
    end
    @(negedge phy_clk);
    wr_valid = 1'b0;
    #1;
    total_cnt++; if (idle !== 1'b1 || local_write_req !== 1'b0) $display("FAIL wr4_end_idle got=%b/%b exp=1/0", idle, local_write_req); else pass_cnt++;
  endtask

  task automatic test_write_stall();
    bit vv [7] = '{1, 1, 1, 1, 0, 1, 1};
    bit rr [7] = '{1, 0, 0, 1, 1, 1, 1};
    bit er [7] = '{1, 1, 1, 1, 0, 1, 0};
    bit eb [7] = '{1, 0, 0, 0, 0, 0, 0};
    bit ew [7] = '{1, 0, 0, 1, 1, 1, 0};
    int beat = 0;
    int taken = 0;
    @(negedge phy_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 25'h140; cmd_len = 7'd3;
    for (int s = 0; s < 7; s++) begin
      @(negedge phy_clk);
      cmd_valid = 1'b0;
      wr_valid = vv[s]; local_ready = rr[s];
      wr_data = 128'hC000 + 128'(beat);
      #1;
      total_cnt++; if (local_write_req !== er[s] || local_burstbegin !== eb[s] || wr_ready !== ew[s])
        $display("FAIL wst_step%0d got=%b%b%b exp=%b%b%b", s, local_write_req, local_burstbegin, wr_ready, er[s], eb[s], ew[s]);
      else pass_cnt++;
      if (s == 2) begin
        total_cnt++; if (local_wdata !== 128'hC001) $display("FAIL wst_hold got=%h exp=c001", local_wdata); else pass_cnt++;
      end
      if (local_write_req && wr_ready) begin
        taken++;
        beat++;
      end
    end
    total_cnt++; if (taken !== 3) $display("FAIL wst_beats got=%0d exp=3", taken); else pass_cnt++;
    @(negedge phy_clk);
    wr_valid = 1'b0; local_ready = 1'b1;
  endtask

  task automatic test_read8();
    @(negedge phy_clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 25'h200; cmd_len = 7'd8;
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rd8_cmd_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    for (int s = 0; s < 4; s++) begin
      @(negedge phy_clk);
      cmd_valid = 1'b0; cmd_len = 7'd1; local_ready = (s == 3);
      #1;
      total_cnt++; if (local_read_req !== 1'b1 || local_burstbegin !== 1'b1 || cmd_ready !== 1'b0)
        $display("FAIL rd8_req_hold cyc%0d got=%b%b%b exp=110", s, local_read_req, local_burstbegin, cmd_ready); else pass_cnt++;
      if (s == 0) begin
        total_cnt++; if (local_size !== 7'd8 || local_address !== 25'h200)
          $display("FAIL rd8_size_addr got=%h/%h exp=8/200", local_size, local_address); else pass_cnt++;
      end
    end
    @(negedge phy_clk);
    #1;
    total_cnt++; if (local_read_req !== 1'b0 || dut.rd_out_q !== 7'd8 || idle !== 1'b0)
      $display("FAIL rd8_issued got=req%b out%0d idle%b exp=req0 out8 idle0", local_read_req, dut.rd_out_q, idle); else pass_cnt++;
    for (int i = 0; i <= 8; i++) begin
      @(negedge phy_clk);
      local_rdata_valid = (i < 8);
      local_rdata = 128'h5000 + 128'(i);
      #1;
      if (i == 0) begin
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL rd8_no_early got=%b exp=0", rd_valid); else pass_cnt++;
      end else begin
        total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 128'h5000 + 128'(i - 1))
          $display("FAIL rd8_ret%0d got=%b/%h exp=1/%h", i - 1, rd_valid, rd_data, 128'h5000 + 128'(i - 1)); else pass_cnt++;
      end
    end
    total_cnt++; if (idle !== 1'b1) $display("FAIL rd8_idle got=%b exp=1", idle); else pass_cnt++;
    @(negedge phy_clk);
    #1;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL rd8_ret_end got=%b exp=0", rd_valid); else pass_cnt++;
  endtask

  task automatic test_two_reads();
    @(negedge phy_clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 25'h0; cmd_len = 7'd40; local_ready = 1'b1;
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL r40_first_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    @(negedge phy_clk);
    cmd_valid = 1'b0;
    #1;
    total_cnt++; if (local_read_req !== 1'b1) $display("FAIL r40_first_req got=%b exp=1", local_read_req); else pass_cnt++;
    // 40 outstanding: a second len-40 read fits only once 16 beats have returned.
    for (int k = 0; k <= 16; k++) begin
      @(negedge phy_clk);
      cmd_valid = 1'b1; cmd_len = 7'd40; local_rdata_valid = (k < 16);
      #1;
      total_cnt++; if (cmd_ready !== (k == 16)) $display("FAIL r40_gate k%0d got=%b exp=%b", k, cmd_ready, (k == 16)); else pass_cnt++;
    end
    @(negedge phy_clk);
    cmd_valid = 1'b0; local_rdata_valid = 1'b1;
    #1;
    total_cnt++; if (local_read_req !== 1'b1 || cmd_ready !== 1'b0)
      $display("FAIL r40_second_req got=%b/%b exp=1/0", local_read_req, cmd_ready); else pass_cnt++;
    @(negedge phy_clk);
    local_rdata_valid = 1'b0;
    #1;
    total_cnt++; if (dut.rd_out_q !== 7'd63) $display("FAIL r40_net got=%0d exp=63", dut.rd_out_q); else pass_cnt++;
    for (int j = 0; j < 63; j++) begin
      @(negedge phy_clk);
      local_rdata_valid = 1'b1;
    end
    @(negedge phy_clk);
    local_rdata_valid = 1'b0;
    #1;
    total_cnt++; if (idle !== 1'b1 || rd_overflow !== 1'b0) $display("FAIL r40_drain got=%b/%b exp=1/0", idle, rd_overflow); else pass_cnt++;
  endtask

  task automatic test_len0_overflow();
    @(negedge phy_clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 25'h3; cmd_len = 7'd0;
    @(negedge phy_clk);
    cmd_valid = 1'b0;
    #1;
    total_cnt++; if (local_size !== 7'd1 || local_read_req !== 1'b1)
      $display("FAIL len0_size got=%0d/%b exp=1/1", local_size, local_read_req); else pass_cnt++;
    @(negedge phy_clk);
    local_rdata_valid = 1'b1;
    #1;
    total_cnt++; if (dut.rd_out_q !== 7'd1) $display("FAIL len0_out got=%0d exp=1", dut.rd_out_q); else pass_cnt++;
    @(negedge phy_clk);
    #1;
    total_cnt++; if (dut.rd_out_q !== 7'd0 || rd_overflow !== 1'b0)
      $display("FAIL ovf_before got=%0d/%b exp=0/0", dut.rd_out_q, rd_overflow); else pass_cnt++;
    @(negedge phy_clk);
    local_rdata_valid = 1'b0;
    #1;
    total_cnt++; if (dut.rd_out_q !== 7'd0 || rd_overflow !== 1'b1)
      $display("FAIL ovf_set got=%0d/%b exp=0/1", dut.rd_out_q, rd_overflow); else pass_cnt++;
    @(negedge phy_clk);
    #1;
    total_cnt++; if (rd_overflow !== 1'b1 || idle !== 1'b1) $display("FAIL ovf_sticky got=%b/%b exp=1/1", rd_overflow, idle); else pass_cnt++;
  endtask

  task automatic test_init_done();
    @(negedge phy_clk);
    local_init_done = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 25'h40; cmd_len = 7'd2;
    #1;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL init_block got=%b exp=0", cmd_ready); else pass_cnt++;
    @(negedge phy_clk);
    wr_valid = 1'b1;
    #1;
    total_cnt++; if (local_write_req !== 1'b0 || idle !== 1'b1) $display("FAIL init_no_accept got=%b/%b exp=0/1", local_write_req, idle); else pass_cnt++;
    @(negedge phy_clk);
    local_init_done = 1'b1; wr_valid = 1'b0;
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL init_release got=%b exp=1", cmd_ready); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge phy_clk);
      cmd_valid = 1'b0; local_init_done = 1'b0; wr_valid = 1'b1;
      #1;
      total_cnt++; if (local_write_req !== 1'b1 || wr_ready !== 1'b1)
        $display("FAIL init_burst_cont beat%0d got=%b/%b exp=1/1", i, local_write_req, wr_ready); else pass_cnt++;
    end
    @(negedge phy_clk);
    wr_valid = 1'b0; local_init_done = 1'b1;
    #1;
    total_cnt++; if (idle !== 1'b1) $display("FAIL init_burst_done got=%b exp=1", idle); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge phy_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 25'h1F0; cmd_len = 7'd4;
    @(negedge phy_clk);
    cmd_valid = 1'b0; wr_valid = 1'b1;
    @(negedge phy_clk);
    #1;
    total_cnt++; if (local_write_req !== 1'b1) $display("FAIL rmid_beat2 got=%b exp=1", local_write_req); else pass_cnt++;
    reset_phy_clk_n = 1'b0;
    @(posedge phy_clk);
    #1;
    total_cnt++; if (local_write_req !== 1'b0 || wr_ready !== 1'b0 || local_burstbegin !== 1'b0)
      $display("FAIL rmid_reqs got=%b%b%b exp=000", local_write_req, wr_ready, local_burstbegin); else pass_cnt++;
    total_cnt++; if (local_address !== 25'h0 || local_size !== 7'h0)
      $display("FAIL rmid_addr got=%h/%h exp=0/0", local_address, local_size); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1 || rd_overflow !== 1'b0) $display("FAIL rmid_idle got=%b/%b exp=1/0", idle, rd_overflow); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rmid_cmd_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    local_init_done = 1'b0;
    #1;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL rmid_cmd_ready_init got=%b exp=0", cmd_ready); else pass_cnt++;
    @(negedge phy_clk);
    local_init_done = 1'b1; wr_valid = 1'b0; reset_phy_clk_n = 1'b1;
    @(negedge phy_clk);
    #1;
    total_cnt++; if (idle !== 1'b1 || local_write_req !== 1'b0) $display("FAIL rmid_after got=%b/%b exp=1/0", idle, local_write_req); else pass_cnt++;
  endtask

  initial begin
    reset_phy_clk_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_be = '0;
    local_init_done = 1'b1; local_ready = 1'b1;
    local_rdata_valid = 1'b0; local_rdata = '0;
    repeat (2) @(posedge phy_clk);
    @(negedge phy_clk);
    reset_phy_clk_n = 1'b1;
    test_reset();
    test_write4();
    test_write_stall();
    test_read8();
    test_two_reads();
    test_len0_overflow();
    test_init_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
